// File: rtl/cycle_bit_serializer_if.sv
// Word-in / bit-out bundle between a word source and cycle_bit_serializer.
// The source drives din/load; the serializer returns ready and the serial stream.
interface cycle_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load;
  logic             ready;
  logic             out;
  logic             out_valid;
  logic             last;
  logic [15:0]      words;

  modport master (
    output din, load,
    input  ready, out, out_valid, last, words
  );

  modport slave (
    input  din, load,
    output ready, out, out_valid, last, words
  );
endinterface

// File: rtl/cycle_bit_serializer.sv
// Parallel-to-serial source: accepts a WIDTH-bit word on load/ready and shifts it
// out one bit per clock, flagging the last bit; back-to-back words have no gap.
module cycle_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                 clk,
  input  logic                 r,
  cycle_bit_serializer_if.slave bus
);
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    bitcnt;
  logic [WIDTH-1:0] shreg;
  logic             at_last;
  logic             accept;

  logic             out_q;
  logic             out_valid_q;
  logic             last_q;
  logic [15:0]      words_q;

  logic             din_first;
  logic [WIDTH-1:0] din_rest;
  logic             sh_bit;
  logic [WIDTH-1:0] sh_rest;

  // NOTE: clocked state is always written with <= so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (r) state <= IDLE;
    else   state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.load) state_next = SHIFT;
      SHIFT:   if (at_last && !bus.load) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ready depends only on state and bitcnt, never on load or din.
  always_comb begin
    at_last   = (state == SHIFT) && (bitcnt == LAST_IDX);
    bus.ready = (state == IDLE) || at_last;
  end

  assign accept = bus.load && bus.ready;

  // Bit-order selection: the word's first bit goes straight to out, the
  // remainder is parked in shreg with the next bit at the exit end.
  always_comb begin
    din_first = bus.din[0];
    din_rest  = bus.din >> 1;
    sh_bit    = shreg[0];
    sh_rest   = shreg >> 1;
    if (MSB_FIRST) begin
      din_first = bus.din[WIDTH-1];
      din_rest  = bus.din << 1;
      sh_bit    = shreg[WIDTH-1];
      sh_rest   = shreg << 1;
    end
  end

  // NOTE: shreg carries no reset; its contents are only observed while
  // out_valid is set, and that is only after a fresh load.
  always_ff @(posedge clk) begin
    if (!r && accept) shreg <= din_rest;
    else if (!r && state == SHIFT && !at_last) shreg <= sh_rest;
  end

  always_ff @(posedge clk) begin
    if (r) begin
      bitcnt      <= '0;
      out_q       <= IDLE_BIT;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      words_q     <= '0;
    end else begin
      if (at_last) words_q <= words_q + 16'd1;

      if (accept) begin
        bitcnt      <= '0;
        out_q       <= din_first;
        out_valid_q <= 1'b1;
        last_q      <= 1'b0;
      end else if (state == SHIFT && !at_last) begin
        bitcnt      <= bitcnt + CW'(1);
        out_q       <= sh_bit;
        out_valid_q <= 1'b1;
        last_q      <= ((bitcnt + CW'(1)) == LAST_IDX);
      end else begin
        out_q       <= IDLE_BIT;
        out_valid_q <= 1'b0;
        last_q      <= 1'b0;
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.last      = last_q;
  assign bus.words     = words_q;
endmodule

// File: tb/tb_cycle_bit_serializer.sv
// Scoreboard bench for cycle_bit_serializer: one MSB-first and one LSB-first
// instance, expected {bit,last} pairs queued at each accepting edge.
module tb_cycle_bit_serializer;
  logic clk = 1'b0;
  logic r   = 1'b1;
  always #5 clk = ~clk;

  cycle_bit_serializer_if #(.WIDTH(8)) m_if ();
  cycle_bit_serializer_if #(.WIDTH(8)) l_if ();

  cycle_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .r(r), .bus(m_if)
  );
  cycle_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .r(r), .bus(l_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] sb_m[$];
  logic [1:0] sb_l[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_m(input logic [7:0] d);
    for (int i = 0; i < 8; i++) sb_m.push_back({d[7-i], 1'(i == 7)});
  endfunction

  function automatic void push_l(input logic [7:0] d);
    for (int i = 0; i < 8; i++) sb_l.push_back({d[i], 1'(i == 7)});
  endfunction

  // Scoreboard monitors: sample half a cycle away from the active edge.
  always @(negedge clk) begin
    logic [1:0] e;
    if (m_if.out_valid) begin
      if (sb_m.size() == 0) check("m_unexpected_bit", 1, 0);
      else begin
        e = sb_m.pop_front();
        check("m_out", 32'(m_if.out), 32'(e[1]));
        check("m_last", 32'(m_if.last), 32'(e[0]));
      end
    end else begin
      check("m_idle_out", 32'(m_if.out), 0);
      check("m_idle_last", 32'(m_if.last), 0);
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (l_if.out_valid) begin
      if (sb_l.size() == 0) check("l_unexpected_bit", 1, 0);
      else begin
        e = sb_l.pop_front();
        check("l_out", 32'(l_if.out), 32'(e[1]));
        check("l_last", 32'(l_if.last), 32'(e[0]));
      end
    end
  end

  task automatic send_m(input logic [7:0] d, input bit keep);
    int n = 0;
    m_if.din  = d;
    m_if.load = 1'b1;
    while (!m_if.ready && n < 40) begin @(negedge clk); n++; end
    if (!m_if.ready) begin
      check("m_ready_timeout", 0, 1);
      m_if.load = 1'b0;
      return;
    end
    @(posedge clk);
    push_m(d);
    #1;
    if (!keep) m_if.load = 1'b0;
  endtask

  task automatic send_l(input logic [7:0] d);
    int n = 0;
    l_if.din  = d;
    l_if.load = 1'b1;
    while (!l_if.ready && n < 40) begin @(negedge clk); n++; end
    if (!l_if.ready) begin
      check("l_ready_timeout", 0, 1);
      l_if.load = 1'b0;
      return;
    end
    @(posedge clk);
    push_l(d);
    #1;
    l_if.load = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    r = 1'b1;
    @(posedge clk);
    sb_m.delete();
    sb_l.delete();
    #1 r = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_if.din = '0; m_if.load = 1'b0;
    l_if.din = '0; l_if.load = 1'b0;
    repeat (2) @(posedge clk);
    #1 r = 1'b0;

    // Reset then idle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_out_valid", 32'(m_if.out_valid), 0);
      check("rst_ready", 32'(m_if.ready), 1);
      check("rst_words", 32'(m_if.words), 0);
    end

    // Single word 0xAC, MSB first.
    send_m(8'hAC, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("ac_valid", 32'(m_if.out_valid), 1);
      check("ac_ready", 32'(m_if.ready), 32'(i == 7));
    end
    @(negedge clk);
    check("ac_words", 32'(m_if.words), 1);
    check("ac_idle_after", 32'(m_if.out_valid), 0);

    // Back-to-back 0xA5, 0x3C with load held high.
    do_reset();
    send_m(8'hA5, 1'b1);
    fork
      send_m(8'h3C, 1'b0);
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        check("strm_valid", 32'(m_if.out_valid), 1);
        check("strm_ready", 32'(m_if.ready), 32'(i == 7 || i == 15));
      end
    join
    @(negedge clk);
    check("strm_words", 32'(m_if.words), 2);
    check("strm_idle_after", 32'(m_if.out_valid), 0);

    // Loads during a busy word are ignored; a load at the last bit is taken.
    do_reset();
    send_m(8'h00, 1'b0);
    @(negedge clk);
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk);
      m_if.din  = 8'hFF;
      m_if.load = (i % 2 == 0);
    end
    @(negedge clk);
    m_if.load = 1'b0;
    check("busy_ready_low", 32'(m_if.ready), 0);
    @(negedge clk);
    check("busy_last_ready", 32'(m_if.ready), 1);
    send_m(8'hFF, 1'b0);
    @(negedge clk);
    check("busy_no_gap", 32'(m_if.out_valid), 1);
    repeat (9) @(negedge clk);
    check("busy_words", 32'(m_if.words), 2);

    // Reset coincident with a load: reset wins.
    @(negedge clk);
    m_if.din = 8'h55; m_if.load = 1'b1; r = 1'b1;
    @(posedge clk);
    #1 r = 1'b0; m_if.load = 1'b0;
    @(negedge clk);
    check("rstld_valid", 32'(m_if.out_valid), 0);
    check("rstld_ready", 32'(m_if.ready), 1);

    // Reset after the 3rd bit of 0xF0, then 0x0F serializes cleanly.
    send_m(8'hF0, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_valid_pre", 32'(m_if.out_valid), 1);
    r = 1'b1;
    @(posedge clk);
    sb_m.delete();
    #1 r = 1'b0;
    @(negedge clk);
    check("mid_out", 32'(m_if.out), 0);
    check("mid_valid", 32'(m_if.out_valid), 0);
    check("mid_words", 32'(m_if.words), 0);
    check("mid_ready", 32'(m_if.ready), 1);
    send_m(8'h0F, 1'b0);
    repeat (9) @(negedge clk);
    check("mid_words_after", 32'(m_if.words), 1);

    // LSB-first instance, then words wrap from 0xFFFF.
    send_l(8'h01);
    repeat (9) @(negedge clk);
    check("lsb_words", 32'(l_if.words), 1);
    force dut_l.words_q = 16'hFFFF;
    #1 release dut_l.words_q;
    @(negedge clk);
    check("wrap_preload", 32'(l_if.words), 32'h0000_FFFF);
    send_l(8'h96);
    repeat (9) @(negedge clk);
    check("wrap_words", 32'(l_if.words), 0);

    check("m_sb_drained", 32'(sb_m.size()), 0);
    check("l_sb_drained", 32'(sb_l.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
